// File: rtl/ahb_arbiter2.sv
// Two-master AHB-Lite arbiter: registered round-robin grant with bounded hold,
// address-phase mux by address owner and write-data mux by data-phase owner.
module ahb_arbiter2 #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_HOLD = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          HBUSREQ0,
  input  logic          HBUSREQ1,
  output logic          HGRANT0,
  output logic          HGRANT1,
  input  logic [AW-1:0] HADDR0,
  input  logic [AW-1:0] HADDR1,
  input  logic [1:0]    HTRANS0,
  input  logic [1:0]    HTRANS1,
  input  logic          HWRITE0,
  input  logic          HWRITE1,
  input  logic [DW-1:0] HWDATA0,
  input  logic [DW-1:0] HWDATA1,
  input  logic          HREADY,
  output logic [AW-1:0] HADDR,
  output logic [1:0]    HTRANS,
  output logic          HWRITE,
  output logic [DW-1:0] HWDATA,
  output logic          HMASTER,
  output logic          HMASTER_D
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  logic       g, o, d;
  logic [7:0] hold_cnt;
  logic       req_own, req_oth, next_grant;

  assign HGRANT0   = ~g;
  assign HGRANT1   = g;
  assign HMASTER   = o;
  assign HMASTER_D = d;

  assign HADDR  = o ? HADDR1  : HADDR0;
  assign HTRANS = o ? HTRANS1 : HTRANS0;
  assign HWRITE = o ? HWRITE1 : HWRITE0;
  assign HWDATA = d ? HWDATA1 : HWDATA0;

  always_comb begin
    req_own    = g ? HBUSREQ1 : HBUSREQ0;
    req_oth    = g ? HBUSREQ0 : HBUSREQ1;
    next_grant = g;
    if (!req_oth && !req_own)
      next_grant = 1'b0;                 // park on the core
    else if (req_oth && (!req_own || hold_cnt >= HOLD_LIM))
      next_grant = ~g;
  end

  // Ownership only advances on completed beats, so a stalled transfer keeps
  // both its address and data owner.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g        <= 1'b0;
      o        <= 1'b0;
      d        <= 1'b0;
      hold_cnt <= 8'd0;
    end else if (HREADY) begin
      d <= o;
      o <= g;
      g <= next_grant;
      if (next_grant != g)
        hold_cnt <= 8'd0;
      else if (o == g && HTRANS[1] && hold_cnt != 8'hFF)
        hold_cnt <= hold_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_ahb_arbiter2.sv
// Self-checking bench for ahb_arbiter2: directed scenarios plus random traffic
// checked against a grant-history reference model.
module tb_ahb_arbiter2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          HBUSREQ0, HBUSREQ1, HGRANT0, HGRANT1;
  logic [AW-1:0] HADDR0, HADDR1, HADDR;
  logic [1:0]    HTRANS0, HTRANS1, HTRANS;
  logic          HWRITE0, HWRITE1, HWRITE;
  logic [DW-1:0] HWDATA0, HWDATA1, HWDATA;
  logic          HREADY, HMASTER, HMASTER_D;

  always #5 clk = ~clk;

  ahb_arbiter2 #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .reset(reset),
    .HBUSREQ0(HBUSREQ0), .HBUSREQ1(HBUSREQ1),
    .HGRANT0(HGRANT0), .HGRANT1(HGRANT1),
    .HADDR0(HADDR0), .HADDR1(HADDR1),
    .HTRANS0(HTRANS0), .HTRANS1(HTRANS1),
    .HWRITE0(HWRITE0), .HWRITE1(HWRITE1),
    .HWDATA0(HWDATA0), .HWDATA1(HWDATA1),
    .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HMASTER(HMASTER), .HMASTER_D(HMASTER_D)
  );

  int checks = 0;
  int errors = 0;

  // own[0] = granted master, own[1] = address owner, own[2] = data owner;
  // every completed beat pushes the new grant in at the front.
  bit own[$];
  int beats;   // active beats the current grant holder has completed

  function automatic void model_reset();
    own   = '{1'b0, 1'b0, 1'b0};
    beats = 0;
  endfunction

  function automatic void model_edge();
    bit req [2];
    bit cur, oth, ng;
    logic [1:0] tr;
    if (HREADY !== 1'b1) return;
    req[0] = HBUSREQ0;
    req[1] = HBUSREQ1;
    cur = own[0];
    oth = !cur;
    tr  = own[1] ? HTRANS1 : HTRANS0;
    if (req[oth] && (!req[cur] || beats >= MH)) ng = oth;
    else if (req[cur])                          ng = cur;
    else                                        ng = 1'b0;
    if (ng != cur)                    beats = 0;
    else if (own[1] == cur && tr[1])  beats = (beats < 255) ? beats + 1 : 255;
    own.push_front(ng);
    void'(own.pop_back());
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [AW-1:0] a [2];
    logic [DW-1:0] w [2];
    logic [1:0]    t [2];
    logic          r [2];
    a = '{HADDR0, HADDR1};
    w = '{HWDATA0, HWDATA1};
    t = '{HTRANS0, HTRANS1};
    r = '{HWRITE0, HWRITE1};
    chk("hgrant0",   HGRANT0,   !own[0]);
    chk("hgrant1",   HGRANT1,   own[0]);
    chk("hmaster",   HMASTER,   own[1]);
    chk("hmaster_d", HMASTER_D, own[2]);
    chk("haddr",     HADDR,     a[own[1]]);
    chk("htrans",    HTRANS,    t[own[1]]);
    chk("hwrite",    HWRITE,    r[own[1]]);
    chk("hwdata",    HWDATA,    w[own[2]]);
  endtask

  // Check outputs against current inputs, then advance model and DUT one edge.
  task automatic step();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sw;
    int t;
    reset    = 1'b1;
    HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b0;
    HADDR0   = 32'h100; HADDR1 = 32'h0;
    HTRANS0  = 2'b00;   HTRANS1 = 2'b00;
    HWRITE0  = 1'b0;    HWRITE1 = 1'b0;
    HWDATA0  = 32'h0BAD_0000; HWDATA1 = 32'h0;
    HREADY   = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Park: no requests, core keeps the bus.
    chk("reset_hgrant0", HGRANT0, 1'b1);
    chk("reset_hmaster", HMASTER, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("park_haddr", HADDR, 32'h100);

    // Debug bridge single write with handover pipeline split.
    HBUSREQ1 = 1'b1;
    HADDR1   = 32'h2000_0040;
    HTRANS1  = 2'b10;
    HWRITE1  = 1'b1;
    HWDATA1  = 32'hDEAD_BEEF;
    sw = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (HMASTER === 1'b1) begin sw = k; break; end
    end
    chk("m1_addr_owner_edge", sw, 2);
    chk("split_hmaster_d", HMASTER_D, 1'b0);
    chk("split_haddr", HADDR, 32'h2000_0040);
    chk("split_hwdata", HWDATA, 32'h0BAD_0000);
    step();
    chk("m1_hwdata", HWDATA, 32'hDEAD_BEEF);
    HBUSREQ1 = 1'b0;
    HTRANS1  = 2'b00;
    step();
    chk("m1_release_grant", HGRANT0, 1'b1);
    for (int i = 0; i < 4; i++) step();

    // Contention: M0 active every cycle, grant alternates every MH beats.
    HBUSREQ0 = 1'b1; HBUSREQ1 = 1'b1;
    HTRANS0  = 2'b10; HTRANS1 = 2'b11;
    sw = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (HGRANT1 === 1'b1) begin sw = k; break; end
    end
    chk("contention_switch_edge", sw, MH + 1);
    for (int i = 0; i < 30; i++) step();

    // Stall while the bridge owns both phases and drops its request.
    HBUSREQ0 = 1'b0; HTRANS0 = 2'b00;
    for (int i = 0; i < 4; i++) step();
    HREADY   = 1'b0;
    HBUSREQ1 = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("stall_frozen_grant", HGRANT1, 1'b1);
    chk("stall_frozen_d", HMASTER_D, 1'b1);
    HREADY = 1'b1;
    step();
    chk("stall_release_grant", HGRANT0, 1'b1);
    for (int i = 0; i < 3; i++) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      HBUSREQ0 = 1'($urandom_range(0, 1));
      HBUSREQ1 = 1'($urandom_range(0, 1));
      HREADY   = ($urandom_range(0, 3) != 0);
      t = $urandom_range(0, 2);
      HTRANS0  = (t == 0) ? 2'b00 : 2'(t + 1);
      t = $urandom_range(0, 2);
      HTRANS1  = (t == 0) ? 2'b00 : 2'(t + 1);
      HADDR0   = $urandom;  HADDR1  = $urandom;
      HWDATA0  = $urandom;  HWDATA1 = $urandom;
      HWRITE0  = 1'($urandom_range(0, 1));
      HWRITE1  = 1'($urandom_range(0, 1));
      step();
    end

    // Async reset while the bridge owns address and data phases.
    HREADY = 1'b1; HBUSREQ0 = 1'b0; HBUSREQ1 = 1'b1; HTRANS1 = 2'b10;
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_hmaster", HMASTER, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_hgrant0", HGRANT0, 1'b1);
    chk("async_hmaster", HMASTER, 1'b0);
    chk("async_hmaster_d", HMASTER_D, 1'b0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0; HBUSREQ1 = 1'b0;
    for (int i = 0; i < 3; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
